stage_f: RTL

STAGE_F -- requirements
Module: stage_f

---
 rtl/stage_f_pkg.sv | 16 +
 rtl/fetch_buf.sv | 27 ++
 rtl/stage_f.sv | 97 +++++++++
 3 files changed

// File: rtl/stage_f_pkg.sv
// Fetch-stage shared constants: FSM encodings, NOP word and alignment helper.
package stage_f_pkg;

  typedef logic [1:0] fstate_t;

  localparam fstate_t ST_IDLE = 2'd0;
  localparam fstate_t ST_WAIT = 2'd1;
  localparam fstate_t ST_KILL = 2'd2;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry instruction buffer holding the word for the PC sitting in decode.
module fetch_buf
  import stage_f_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        consume,
  input  logic        flush,
  input  logic [31:0] din,
  output logic        valid,
  output logic [31:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= NOP;
    end else if (flush || consume) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end
  end

endmodule

// File: rtl/stage_f.sv
// Fetch stage: one outstanding imem request, redirect kill, decode-side buffer.
module stage_f
  import stage_f_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        PCSrcW,
  input  logic [31:0] ResultW,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic [31:0] RDD,
  output logic        ImemStallF
);

  fstate_t     state;
  fstate_t     state_nx;
  logic        dvalid;
  logic        redirect;
  logic        accept;
  logic        resp;
  logic        hit;
  logic [31:0] target;
  logic        buf_valid;
  logic [31:0] buf_data;

  assign redirect = PCSrcW | PCSrcE;
  assign target   = word_align(PCSrcW ? ResultW : PCTargetE);
  assign resp     = (state == ST_WAIT) & imem_rvalid;
  assign hit      = resp & ~redirect;

  // Requests only go out when fetch can move, so a response always belongs to decode.
  assign imem_req  = rst & ~StallF & ~redirect
                   & ((state == ST_IDLE) | resp);
  assign imem_addr = PCF;
  assign accept    = imem_req & imem_ready;
  assign PCPlus4F  = PCF + 32'd4;

  assign ImemStallF = dvalid & ~redirect & ~buf_valid & ~resp;
  assign RDD        = buf_valid ? buf_data
                    : (hit ? imem_rdata : NOP);

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid) state_nx = accept ? ST_WAIT : ST_IDLE;
        else if (redirect) state_nx = ST_KILL;
      end
      ST_KILL: begin
        if (imem_rvalid) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      PCF    <= word_align(RESET_PC);
      dvalid <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (1'b1)
        redirect: PCF <= target;
        accept:   PCF <= PCPlus4F;
        default:  PCF <= PCF;
      endcase
      if (redirect) dvalid <= 1'b0;
      else if (!StallF) dvalid <= accept;
    end
  end

  fetch_buf u_buf (
    .clk     (clk),
    .rst_n   (rst),
    .load    (hit & StallF),
    .consume (~StallF),
    .flush   (redirect),
    .din     (imem_rdata),
    .valid   (buf_valid),
    .data    (buf_data)
  );

endmodule
